// File: rtl/bus_io.sv
// CPU-facing byte bus with a 240-byte RAM window, a 4-deep transmit FIFO
// and a single-byte receive holding register, all on one shared tri-state
// data bus. TX pushes and RX pops fire only on the first edge of a strobe.
module bus_io (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ram_wc,
    input  logic       ram_rc,
    input  logic [7:0] o_a,
    inout  wire  [7:0] o_d,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam logic [7:0] RAM_TOP = 8'hEF;
    localparam logic [7:0] ADDR_TX = 8'hF0;
    localparam logic [7:0] ADDR_ST = 8'hF1;
    localparam logic [7:0] ADDR_RX = 8'hF2;

    logic [7:0] ram_mem [0:239];

    logic       wc_prev_q, rc_prev_q;
    logic [1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic       ovf_q, ovf_d;
    logic       rx_full_q, rx_full_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic [7:0] tx_mem_q [0:3];

    logic       rd_en, wc_rise, rc_rise;
    logic       tx_full, tx_empty, tx_pop, tx_push, push_req;
    logic       rx_pop, rx_cap;
    logic [7:0] rd_data, status;

    // Strobe qualification: a simultaneous write and read is a write only,
    // and edges come from the registered strobe history, not the address.
    assign rd_en   = ram_rc & ~ram_wc;
    assign wc_rise = ram_wc & ~wc_prev_q;
    assign rc_rise = rd_en & ~rc_prev_q;

    assign tx_full  = (tx_cnt_q == 3'd4);
    assign tx_empty = (tx_cnt_q == 3'd0);
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem_q[tx_rd_ptr_q];
    assign rx_ready = ~rx_full_q;
    assign status   = {3'b000, ovf_q, rx_full_q, tx_full, tx_empty, 1'b0};

    // Bus is driven only during a pure read; otherwise the CPU owns it.
    assign o_d = rd_en ? rd_data : 8'bz;

    // Next-state logic for the TX FIFO, overflow flag and RX holding register.
    always_comb begin
        tx_pop      = tx_valid & tx_ready;
        push_req    = wc_rise & (o_a == ADDR_TX);
        // A full FIFO still accepts a push when a pop frees a slot this edge.
        tx_push     = push_req & (~tx_full | tx_pop);
        tx_wr_ptr_d = tx_wr_ptr_q + {1'b0, tx_push};
        tx_rd_ptr_d = tx_rd_ptr_q + {1'b0, tx_pop};
        tx_cnt_d    = tx_cnt_q + {2'b00, tx_push} - {2'b00, tx_pop};

        ovf_d = ovf_q;
        if (ram_wc && (o_a == ADDR_ST))
            ovf_d = 1'b0;
        if (push_req && tx_full && !tx_pop)
            ovf_d = 1'b1;

        // Capture is only possible while empty, so a pop of a full register
        // always wins over a byte arriving on the same edge.
        rx_pop    = rc_rise & (o_a == ADDR_RX);
        rx_cap    = rx_valid & ~rx_full_q;
        rx_full_d = rx_full_q;
        if (rx_cap)
            rx_full_d = 1'b1;
        else if (rx_pop)
            rx_full_d = 1'b0;
        rx_byte_d = rx_cap ? rx_data : rx_byte_q;
    end

    // Combinational read mux decoded from the address.
    always_comb begin
        rd_data = 8'h00;
        if (o_a <= RAM_TOP)
            rd_data = ram_mem[o_a];
        else if (o_a == ADDR_ST)
            rd_data = status;
        else if (o_a == ADDR_RX)
            rd_data = rx_byte_q;
    end

    // Control state: pointers, count, flags and strobe history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wc_prev_q   <= 1'b0;
            rc_prev_q   <= 1'b0;
            tx_wr_ptr_q <= 2'd0;
            tx_rd_ptr_q <= 2'd0;
            tx_cnt_q    <= 3'd0;
            ovf_q       <= 1'b0;
            rx_full_q   <= 1'b0;
        end else begin
            wc_prev_q   <= ram_wc;
            rc_prev_q   <= ram_rc;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            ovf_q       <= ovf_d;
            rx_full_q   <= rx_full_d;
        end
    end

    // FIFO slots are cleared by reset so tx_data idles at 0x00.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tx_slot
            // Load this slot when the write pointer selects it on a push.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    tx_mem_q[gi] <= 8'h00;
                else if (tx_push && (tx_wr_ptr_q == 2'(gi)))
                    tx_mem_q[gi] <= o_d;
            end
        end
    endgenerate

    // RX data byte keeps its value across reset; only the full flag clears.
    always_ff @(posedge clk) begin
        rx_byte_q <= rx_byte_d;
    end

    // RAM is written on every edge of a held write strobe in its window.
    always_ff @(posedge clk) begin
        if (ram_wc && (o_a <= RAM_TOP))
            ram_mem[o_a] <= o_d;
    end

endmodule
